// File: rtl/fwd_pkg.sv
// Shared types and defaults for the forwarding / load-use hazard scoreboard.
package fwd_pkg;
  localparam int DW_DEF    = 8;
  localparam int NREG_DEF  = 8;
  localparam int NSRC_DEF  = 2;
  localparam int DEPTH_DEF = 3;
  localparam int LDSTG_DEF = 1;

  localparam logic WE_ACTIVE = 1'b0;

  // Shadow of one in-flight write-back at the default widths.
  typedef struct packed {
    logic                        valid;
    logic                        weN;
    logic [$clog2(NREG_DEF)-1:0] dst;
    logic                        load;
    logic [DW_DEF-1:0]           data;
    logic                        rdy;
  } entry_t;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-stage read/issue, EX/MEM result and register-file write-back bundle.
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NSRC = NSRC_DEF
);
  localparam int RW = $clog2(NREG);

  logic                       advance;
  logic                       issueValid;
  logic                       issueWeN;
  logic [RW-1:0]              issueDst;
  logic                       issueLoad;
  logic [NSRC-1:0][RW-1:0]    srcReg;
  logic [NSRC-1:0][DW-1:0]    srcRegVal;
  logic [DW-1:0]              exRes;
  logic [DW-1:0]              memRes;
  logic [NSRC-1:0][DW-1:0]    fwdVal;
  logic [NSRC-1:0]            fwdHit;
  logic                       stall;
  logic                       wbWeN;
  logic [RW-1:0]              wbDst;
  logic [DW-1:0]              wbData;
  logic [15:0]                stallCnt;

  modport master (
    output advance, issueValid, issueWeN, issueDst, issueLoad,
           srcReg, srcRegVal, exRes, memRes,
    input  fwdVal, fwdHit, stall, wbWeN, wbDst, wbData, stallCnt
  );

  modport slave (
    input  advance, issueValid, issueWeN, issueDst, issueLoad,
           srcReg, srcRegVal, exRes, memRes,
    output fwdVal, fwdHit, stall, wbWeN, wbDst, wbData, stallCnt
  );
endinterface

// File: rtl/fwd_match.sv
// One ID operand channel: youngest-first producer search over the tracked stages.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int  DW    = DW_DEF,
  parameter int  RW    = $clog2(NREG_DEF),
  parameter int  DEPTH = DEPTH_DEF,
  parameter int  LDSTG = LDSTG_DEF,
  parameter type ent_t = entry_t
)(
  input  logic                  en,
  input  ent_t [DEPTH-1:0]      ents,
  input  logic [RW-1:0]         src,
  input  logic [DW-1:0]         srcVal,
  input  logic [DW-1:0]         exRes,
  input  logic [DW-1:0]         memRes,
  output logic [DW-1:0]         val,
  output logic                  hit,
  output logic                  req
);
  logic found;

  always_comb begin
    val   = srcVal;
    hit   = 1'b0;
    req   = 1'b0;
    found = 1'b0;
    if (en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && ents[k].valid && ents[k].weN == WE_ACTIVE && ents[k].dst == src) begin
          found = 1'b1;
          // Results still on the EX / MEM buses are picked up before they are latched.
          if (k == 0 && !ents[k].load) begin
            val = exRes;
            hit = 1'b1;
          end else if (k == LDSTG && ents[k].load) begin
            val = memRes;
            hit = 1'b1;
          end else if (ents[k].rdy) begin
            val = ents[k].data;
            hit = 1'b1;
          end else begin
            req = 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit; shadows EX..WB write-backs and drives the regfile write port.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LDSTG = LDSTG_DEF
)(
  input  logic             clk,
  input  logic             rstN,
  fwd_scoreboard_if.slave  bus
);
  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic          valid;
    logic          weN;
    logic [RW-1:0] dst;
    logic          load;
    logic [DW-1:0] data;
    logic          rdy;
  } ent_t;

  localparam ent_t BUBBLE = '{valid: 1'b0, weN: !WE_ACTIVE, dst: '0, load: 1'b0, data: '0, rdy: 1'b0};

  ent_t [DEPTH-1:0]        ents, nxt;
  logic [NSRC-1:0]         req;
  logic [NSRC-1:0]         fwd_hit;
  logic [NSRC-1:0][DW-1:0] fwd_val;
  logic                    stall;
  logic [15:0]             cnt;

  for (genvar n = 0; n < NSRC; n++) begin : g_ch
    fwd_match #(
      .DW(DW), .RW(RW), .DEPTH(DEPTH), .LDSTG(LDSTG), .ent_t(ent_t)
    ) u_match (
      .en     (bus.issueValid),
      .ents   (ents),
      .src    (bus.srcReg[n]),
      .srcVal (bus.srcRegVal[n]),
      .exRes  (bus.exRes),
      .memRes (bus.memRes),
      .val    (fwd_val[n]),
      .hit    (fwd_hit[n]),
      .req    (req[n])
    );
  end

  assign stall = bus.issueValid && (|req);

  always_comb begin
    nxt = ents;
    for (int k = DEPTH-1; k > 0; k--) begin
      nxt[k] = ents[k-1];
      if (k == 1 && ents[0].valid && !ents[0].load) begin
        nxt[k].data = bus.exRes;
        nxt[k].rdy  = 1'b1;
      end
      if (k-1 == LDSTG && ents[k-1].load) begin
        nxt[k].data = bus.memRes;
        nxt[k].rdy  = 1'b1;
      end
    end
    // A stalled ID turns the EX slot into a bubble.
    nxt[0] = BUBBLE;
    if (bus.issueValid && !stall) begin
      nxt[0].valid = 1'b1;
      nxt[0].weN   = bus.issueWeN;
      nxt[0].dst   = bus.issueDst;
      nxt[0].load  = bus.issueLoad;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < DEPTH; k++) ents[k] <= BUBBLE;
      cnt <= '0;
    end else if (bus.advance) begin
      ents <= nxt;
      if (stall && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  assign bus.fwdVal   = fwd_val;
  assign bus.fwdHit   = fwd_hit;
  assign bus.stall    = stall;
  assign bus.stallCnt = cnt;
  assign bus.wbWeN    = !(ents[DEPTH-1].valid && ents[DEPTH-1].weN == WE_ACTIVE);
  assign bus.wbDst    = ents[DEPTH-1].dst;
  assign bus.wbData   = ents[DEPTH-1].data;
endmodule
